// File: rtl/counter_sweep_ctrl.sv
// Sequencer driving the CE/SCLR/UP/LOAD/L inputs of an up/down loadable counter
// through programmable clear/load/sweep runs. Define CNT_CHECK_EN to add cnt_q readback checking.
module counter_sweep_ctrl #(
  parameter int WIDTH       = 32,
  parameter int PRESCALE_W  = 16,
  parameter int REPEAT_W    = 16,
  parameter int COUNTER_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            cfg_mode,
  input  logic [WIDTH-1:0]      cfg_start,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [REPEAT_W-1:0]   cfg_repeat,
  input  logic [WIDTH-1:0]      cnt_q,
  output logic                  cnt_ce,
  output logic                  cnt_sclr,
  output logic                  cnt_up,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_l,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [REPEAT_W-1:0]   sweep_cnt,
  output logic                  chk_err
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN_UP, RUN_DN, SWEEP_END, DONE} state_t;

  state_t                state, state_nx;
  logic [1:0]            mode_r;
  logic [WIDTH-1:0]      start_r, limit_r, shadow, shadow_nx, target_dn, l_nx;
  logic [PRESCALE_W-1:0] prescale_r, psc, psc_nx;
  logic [REPEAT_W-1:0]   repeat_r, sweep_nx, sweep_inc;
  logic                  ce_nx, sclr_nx, up_nx, load_nx, done_nx, err_nx;
  logic                  accept, cfg_ok, tick, mismatch;

  assign accept    = (state == IDLE) && start && !abort;
  assign cfg_ok    = (cfg_mode == 2'b01) ? (cfg_limit <= cfg_start) :
                     (cfg_mode != 2'b11) && (cfg_limit >= cfg_start);
  assign tick      = (psc == prescale_r);
  assign target_dn = (mode_r == 2'b10) ? start_r : limit_r;
  assign sweep_inc = (&sweep_cnt) ? sweep_cnt : sweep_cnt + REPEAT_W'(1);
  assign busy      = (state != IDLE);

  // Strobes are computed from the transition being taken, so they line up with the new state.
  always_comb begin
    state_nx  = state;
    ce_nx     = 1'b0;
    sclr_nx   = 1'b0;
    load_nx   = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    up_nx     = cnt_up;
    l_nx      = cnt_l;
    shadow_nx = shadow;
    psc_nx    = psc;
    sweep_nx  = sweep_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cfg_ok) begin
            state_nx  = CLEAR;
            sclr_nx   = 1'b1;
            shadow_nx = '0;
            sweep_nx  = '0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_nx  = LOAD;
        load_nx   = 1'b1;
        ce_nx     = 1'b1;
        l_nx      = start_r;
        shadow_nx = start_r;
      end
      LOAD: begin
        state_nx = (mode_r == 2'b01) ? RUN_DN : RUN_UP;
        psc_nx   = '0;
      end
      RUN_UP: begin
        psc_nx = tick ? '0 : psc + PRESCALE_W'(1);
        if (tick) begin
          if (shadow != limit_r) begin
            ce_nx     = 1'b1;
            up_nx     = 1'b1;
            shadow_nx = shadow + WIDTH'(1);
          end else if (mode_r == 2'b10) begin
            state_nx = RUN_DN;
            psc_nx   = '0;
          end else begin
            state_nx = SWEEP_END;
          end
        end
      end
      RUN_DN: begin
        psc_nx = tick ? '0 : psc + PRESCALE_W'(1);
        if (tick) begin
          if (shadow != target_dn) begin
            ce_nx     = 1'b1;
            up_nx     = 1'b0;
            shadow_nx = shadow - WIDTH'(1);
          end else begin
            state_nx = SWEEP_END;
          end
        end
      end
      SWEEP_END: begin
        sweep_nx = sweep_inc;
        if ((repeat_r != '0) && (sweep_inc == repeat_r)) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          state_nx  = LOAD;
          load_nx   = 1'b1;
          ce_nx     = 1'b1;
          l_nx      = start_r;
          shadow_nx = start_r;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort or readback mismatch: drop everything, keep the counter where it is.
    if ((state != IDLE) && (abort || mismatch)) begin
      state_nx  = IDLE;
      ce_nx     = 1'b0;
      sclr_nx   = 1'b0;
      load_nx   = 1'b0;
      done_nx   = 1'b0;
      up_nx     = cnt_up;
      l_nx      = cnt_l;
      shadow_nx = shadow;
      sweep_nx  = sweep_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_ce     <= 1'b0;
      cnt_sclr   <= 1'b0;
      cnt_up     <= 1'b0;
      cnt_load   <= 1'b0;
      cnt_l      <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      sweep_cnt  <= '0;
      shadow     <= '0;
      psc        <= '0;
      mode_r     <= '0;
      start_r    <= '0;
      limit_r    <= '0;
      prescale_r <= '0;
      repeat_r   <= '0;
    end else begin
      state     <= state_nx;
      cnt_ce    <= ce_nx;
      cnt_sclr  <= sclr_nx;
      cnt_up    <= up_nx;
      cnt_load  <= load_nx;
      cnt_l     <= l_nx;
      done      <= done_nx;
      cfg_err   <= err_nx;
      sweep_cnt <= sweep_nx;
      shadow    <= shadow_nx;
      psc       <= psc_nx;
      if (accept) begin
        mode_r     <= cfg_mode;
        start_r    <= cfg_start;
        limit_r    <= cfg_limit;
        prescale_r <= cfg_prescale;
        repeat_r   <= cfg_repeat;
      end
    end
  end

`ifdef CNT_CHECK_EN
  // shadow_dly[COUNTER_LAT-1] is what cnt_q should show this cycle.
  logic [COUNTER_LAT-1:0][WIDTH-1:0] shadow_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dly <= '0;
    end else begin
      shadow_dly[0] <= shadow;
      for (int i = 1; i < COUNTER_LAT; i++) shadow_dly[i] <= shadow_dly[i-1];
    end
  end

  assign mismatch = ((state == RUN_UP) || (state == RUN_DN) || (state == SWEEP_END)) &&
                    (cnt_q != shadow_dly[COUNTER_LAT-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  chk_err <= 1'b0;
    else if (accept && cfg_ok) chk_err <= 1'b0;
    else if (mismatch)        chk_err <= 1'b1;
  end
`else
  logic unused_chk;
  assign unused_chk = (^cnt_q) ^ (COUNTER_LAT > 0);
  assign mismatch   = 1'b0;
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl: a behavioural up/down counter closes the loop,
// table and random sweeps are scored against sweep-level expectations.
module tb_counter_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_start, cfg_limit, cnt_q, cnt_l;
  logic [15:0] cfg_prescale, cfg_repeat, sweep_cnt;
  logic        cnt_ce, cnt_sclr, cnt_up, cnt_load, busy, done, cfg_err, chk_err;

  counter_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_prescale(cfg_prescale),
    .cfg_repeat(cfg_repeat), .cnt_q(cnt_q), .cnt_ce(cnt_ce), .cnt_sclr(cnt_sclr),
    .cnt_up(cnt_up), .cnt_load(cnt_load), .cnt_l(cnt_l), .busy(busy), .done(done),
    .cfg_err(cfg_err), .sweep_cnt(sweep_cnt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // The counter being driven: SCLR beats CE, LOAD beats UP/DOWN, one cycle latency.
  logic [31:0] q = '0;
  logic [31:0] q_off = '0;
  always @(posedge clk) begin
    if (cnt_sclr)    q <= '0;
    else if (cnt_ce) q <= cnt_load ? cnt_l : (cnt_up ? q + 32'd1 : q - 32'd1);
  end
  assign cnt_q = q + q_off;

  // Cumulative event monitor, sampled mid-cycle.
  int cyc_t = 0, n_sclr = 0, n_load = 0, n_up = 0, n_dn = 0, n_done = 0, n_err = 0;
  int n_busy = 0, n_gap = 0, t_sclr = 0, t_load = 0, t_ce1 = 0, t_cel = 0, t_done = 0;
  int prev_t = 0, run_p = 0, run_c = 0;
  bit have_prev = 0, prev_up = 0, need_first = 0;
  always @(negedge clk) begin
    cyc_t++;
    if (cnt_sclr) begin n_sclr++; t_sclr = cyc_t; end
    if (cnt_ce && cnt_load) begin
      n_load++; t_load = cyc_t; have_prev = 0; need_first = 1;
    end
    if (cnt_ce && !cnt_load) begin
      if (cnt_up) n_up++; else n_dn++;
      if (need_first) begin t_ce1 = cyc_t; need_first = 0; end
      t_cel = cyc_t;
      if (have_prev && prev_up == cnt_up && (cyc_t - prev_t) != run_p + 1) n_gap++;
      have_prev = 1; prev_up = cnt_up; prev_t = cyc_t;
    end
    if (done) begin n_done++; t_done = cyc_t; end
    if (cfg_err) n_err++;
    if (busy) n_busy++;
  end

  typedef struct {
    logic [1:0] mode;
    int s, l, p, r;
    int err, ups, dns, q, sw;
  } vec_t;

  int tests = 0, fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sweep-level reference: counts per sweep come straight from |limit-start|.
  function automatic vec_t ref_model(input vec_t v);
    vec_t e = v;
    int span;
    bit ok;
    ok = (v.mode == 2'd1) ? (v.l <= v.s) : (v.mode != 2'd3) && (v.l >= v.s);
    span = (v.l >= v.s) ? v.l - v.s : v.s - v.l;
    e.err = ok ? 0 : 1;
    e.ups = (ok && v.mode != 2'd1) ? span * v.r : 0;
    e.dns = (ok && v.mode != 2'd0) ? span * v.r : 0;
    e.q   = (v.mode == 2'd2) ? v.s : v.l;
    e.sw  = v.r;
    return e;
  endfunction

  task automatic do_run(input vec_t v, input string tag);
    int b_sclr, b_load, b_up, b_dn, b_done, b_err, b_busy, b_gap, n;
    @(posedge clk); #1;
    b_sclr = n_sclr; b_load = n_load; b_up = n_up; b_dn = n_dn; b_done = n_done;
    b_err = n_err; b_busy = n_busy; b_gap = n_gap;
    run_p = v.p; run_c = cyc_t;
    cfg_mode = v.mode; cfg_start = v.s; cfg_limit = v.l;
    cfg_prescale = 16'(v.p); cfg_repeat = 16'(v.r); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Config must be ignored once accepted.
    cfg_mode = 2'($urandom); cfg_start = $urandom; cfg_limit = $urandom;
    cfg_prescale = 16'($urandom); cfg_repeat = 16'($urandom);
    n = 0;
    @(negedge clk);
    while (busy && n < 4000) begin @(negedge clk); n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
      abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    end
    @(negedge clk);
    check({tag, "_cfg_err"}, n_err - b_err, v.err);
    check({tag, "_chk_err"}, int'(chk_err), 0);
    if (v.err == 0) begin
      check({tag, "_sclr"},  n_sclr - b_sclr, 1);
      check({tag, "_loads"}, n_load - b_load, v.r);
      check({tag, "_ce_up"}, n_up - b_up, v.ups);
      check({tag, "_ce_dn"}, n_dn - b_dn, v.dns);
      check({tag, "_gaps"},  n_gap - b_gap, 0);
      check({tag, "_done"},  n_done - b_done, 1);
      check({tag, "_q"},     int'(q), v.q);
      check({tag, "_sweeps"}, int'(sweep_cnt), v.sw);
    end else begin
      check({tag, "_busy"},  n_busy - b_busy, 0);
      check({tag, "_activity"}, (n_sclr - b_sclr) + (n_load - b_load) + (n_up - b_up) +
                                (n_dn - b_dn) + (n_done - b_done), 0);
    end
  endtask

  vec_t vecs[8];
  vec_t rv;
  int   n, b_done, b_err, sw_hold;
  logic [31:0] q_hold;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_mode = '0; cfg_start = '0;
    cfg_limit = '0; cfg_prescale = '0; cfg_repeat = '0;
    @(posedge clk); #1;
    check("reset_ctl", int'({busy, cnt_ce, cnt_sclr, cnt_up, cnt_load, done, cfg_err, chk_err}), 0);
    check("reset_l", int'(cnt_l), 0);
    check("reset_sweep", int'(sweep_cnt), 0);
    @(posedge clk); #1; rst = 1'b0;

    //           mode  s   l  p  r  err ups dns  q  sw
    vecs[0] = '{2'd0, 10, 15, 0, 1, 0,  5,  0, 15, 1};
    vecs[1] = '{2'd2,  0,  3, 2, 2, 0,  6,  6,  0, 2};
    vecs[2] = '{2'd0, 20,  5, 0, 1, 1,  0,  0,  0, 0};
    vecs[3] = '{2'd3,  0,  5, 0, 1, 1,  0,  0,  0, 0};
    vecs[4] = '{2'd1,  9,  4, 1, 1, 0,  0,  5,  4, 1};
    vecs[5] = '{2'd0,  7,  7, 0, 3, 0,  0,  0,  7, 3};
    vecs[6] = '{2'd2,  5,  5, 0, 1, 0,  0,  0,  5, 1};
    vecs[7] = '{2'd1,  3,  8, 0, 1, 1,  0,  0,  0, 0};
    for (int i = 0; i < 8; i++) do_run(vecs[i], $sformatf("vec%0d", i));

    // Cycle-exact placement of the first sweep, relative to the edge that samples start.
    do_run(vecs[0], "t1");
    check("t1_sclr_at", t_sclr - run_c - 1, 1);
    check("t1_load_at", t_load - run_c - 1, 2);
    check("t1_ce_first", t_ce1 - run_c - 1, 4);
    check("t1_ce_last", t_cel - run_c - 1, 8);
    check("t1_done_at", t_done - run_c - 1, 10);

    for (int i = 0; i < 12; i++) begin
      rv.mode = 2'($urandom_range(0, 3));
      rv.s = $urandom_range(0, 7);
      rv.l = $urandom_range(0, 7);
      rv.p = $urandom_range(0, 2);
      rv.r = $urandom_range(1, 3);
      do_run(ref_model(rv), $sformatf("rnd%0d", i));
    end

    // Continuous run, then abort in the middle of a RUN_UP sweep.
    @(posedge clk); #1;
    run_p = 0; cfg_mode = 2'd0; cfg_start = 0; cfg_limit = 2; cfg_prescale = 0; cfg_repeat = 0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    b_done = n_done;
    n = 0;
    while (sweep_cnt < 16'd3 && n < 200) begin @(negedge clk); n++; end
    check("cont_sweeps", int'(sweep_cnt >= 16'd3), 1);
    check("cont_busy", int'(busy), 1);
    n = 0;
    @(negedge clk);
    while (!(cnt_ce && !cnt_load) && n < 50) begin @(negedge clk); n++; end
    sw_hold = int'(sweep_cnt);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_strobes", int'({cnt_ce, cnt_sclr, cnt_load, done}), 0);
    q_hold = q;
    repeat (4) @(negedge clk);
    check("abort_q_hold", int'(q), int'(q_hold));
    check("abort_sweep_hold", int'(sweep_cnt), sw_hold);
    check("abort_no_done", n_done - b_done, 0);

    // start and abort together in IDLE: abort wins, even over a bad config.
    @(posedge clk); #1;
    b_err = n_err;
    cfg_mode = 2'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_wins_busy", int'(busy), 0);
    @(negedge clk);
    check("abort_wins_no_err", n_err - b_err, 0);

    // Asynchronous reset in the middle of a continuous run.
    @(posedge clk); #1;
    cfg_mode = 2'd0; cfg_start = 5; cfg_limit = 6; cfg_prescale = 0; cfg_repeat = 0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_running", int'(busy && sweep_cnt != 16'd0), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_ctl", int'({busy, cnt_ce, cnt_sclr, cnt_up, cnt_load, done, cfg_err, chk_err}), 0);
    check("rst_l", int'(cnt_l), 0);
    check("rst_sweep", int'(sweep_cnt), 0);
    @(posedge clk); #1; rst = 1'b0;

`ifdef CNT_CHECK_EN
    // Counter readback disagrees by one during RUN_UP.
    @(posedge clk); #1;
    run_p = 0; cfg_mode = 2'd0; cfg_start = 0; cfg_limit = 20; cfg_prescale = 0; cfg_repeat = 1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    b_done = n_done;
    n = 0;
    @(negedge clk);
    while (!(cnt_ce && !cnt_load) && n < 50) begin @(negedge clk); n++; end
    q_off = 32'd1;
    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    check("chk_err_set", int'(chk_err), 1);
    check("chk_idle", int'(busy), 0);
    check("chk_no_done", n_done - b_done, 0);
    q_off = '0;
    do_run(ref_model('{2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0}), "chk_restart");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
